// File: rtl/key_repeat_conditioner.sv
// Turns three raw active-low push-buttons into clean active-low strobes for the
// theta adjustment stage: 2-FF sync, per-key debounce, one-shot plus auto-repeat.
module key_repeat_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned PULSE_CYCLES    = 50000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_key_inc_n,
  input  logic       i_key_dec_n,
  input  logic       i_key_rst_n,
  output logic       o_increase,
  output logic       o_decrease,
  output logic       o_theta_reset,
  output logic [1:0] o_state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FIRE    = 2'd1,
    ST_HOLD    = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_t;

  localparam logic [31:0] DB_LAST    = 32'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] PULSE_LAST = 32'(PULSE_CYCLES - 1);
  localparam logic [31:0] DELAY_LIM  = 32'(REPEAT_DELAY);
  localparam logic [31:0] PERIOD_LIM = 32'(REPEAT_PERIOD);

  // Key index: 0 = inc, 1 = dec, 2 = theta reset. Levels are active-low.
  logic [2:0] raw_n;
  logic [2:0] sync1_q;
  logic [2:0] sync2_q;
  logic [2:0] pressed;

  assign raw_n = {i_key_rst_n, i_key_dec_n, i_key_inc_n};

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= raw_n;
      sync2_q <= sync1_q;
    end
  end

  for (genvar k = 0; k < 3; k++) begin : g_debounce
    logic        lvl_q, lvl_d;
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
      lvl_d = lvl_q;
      cnt_d = '0;
      if (sync2_q[k] != lvl_q) begin
        if (cnt_q == DB_LAST) begin
          lvl_d = sync2_q[k];
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
        lvl_q <= 1'b1;
        cnt_q <= '0;
      end else begin
        lvl_q <= lvl_d;
        cnt_q <= cnt_d;
      end
    end

    assign pressed[k] = ~lvl_q;
  end

  logic p_inc, p_dec, p_rst;
  assign p_inc = pressed[0];
  assign p_dec = pressed[1];
  assign p_rst = pressed[2];

  state_t      state_q, state_d;
  logic        dir_q, dir_d;       // 0 = increase, 1 = decrease
  logic        first_q, first_d;   // current FIRE/HOLD belongs to the initial press
  logic [31:0] timer_q, timer_d;
  logic        inc_q, inc_d;
  logic        dec_q, dec_d;
  logic        trst_q, trst_d;
  logic        held, opposite;

  assign held     = dir_q ? p_dec : p_inc;
  assign opposite = dir_q ? p_inc : p_dec;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    first_d = first_q;
    timer_d = timer_q;

    if (p_rst) begin
      state_d = ST_IDLE;
      timer_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (p_inc && p_dec) begin
            state_d = ST_LOCKOUT;
          end else if (p_inc ^ p_dec) begin
            state_d = ST_FIRE;
            dir_d   = p_dec;
            first_d = 1'b1;
            timer_d = '0;
          end
        end
        ST_FIRE: begin
          if (timer_q == PULSE_LAST) begin
            state_d = ST_HOLD;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 32'd1;
          end
        end
        ST_HOLD: begin
          // Release wins over a coinciding repeat expiry.
          if (!held) begin
            state_d = ST_IDLE;
          end else if (opposite) begin
            state_d = ST_LOCKOUT;
          end else if (timer_q == (first_q ? DELAY_LIM : PERIOD_LIM)) begin
            state_d = ST_FIRE;
            first_d = 1'b0;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 32'd1;
          end
        end
        ST_LOCKOUT: begin
          if (!p_inc && !p_dec) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Strobes are decoded from the next state so they register in step with it.
    inc_d  = !((state_d == ST_FIRE) && !dir_d);
    dec_d  = !((state_d == ST_FIRE) &&  dir_d);
    trst_d = !p_rst;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      dir_q   <= 1'b0;
      first_q <= 1'b0;
      timer_q <= '0;
      inc_q   <= 1'b1;
      dec_q   <= 1'b1;
      trst_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      first_q <= first_d;
      timer_q <= timer_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
      trst_q  <= trst_d;
    end
  end

  assign o_increase    = inc_q;
  assign o_decrease    = dec_q;
  assign o_theta_reset = trst_q;
  assign o_state       = state_q;

endmodule

// File: tb/tb_key_repeat_conditioner.sv
// Scoreboard bench for key_repeat_conditioner: stimulus queues expected strobe
// pulses (channel, falling cycle, width); a monitor pops one per completed pulse.
module tb_key_repeat_conditioner;

  localparam int unsigned DB = 4;
  localparam int unsigned PW = 3;
  localparam int unsigned RD = 20;
  localparam int unsigned RP = 10;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       k_inc = 1'b1;
  logic       k_dec = 1'b1;
  logic       k_rst = 1'b1;
  logic       o_increase, o_decrease, o_theta_reset;
  logic [1:0] o_state;

  key_repeat_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .PULSE_CYCLES   (PW),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_key_inc_n  (k_inc),
    .i_key_dec_n  (k_dec),
    .i_key_rst_n  (k_rst),
    .o_increase   (o_increase),
    .o_decrease   (o_decrease),
    .o_theta_reset(o_theta_reset),
    .o_state      (o_state)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int unsigned ch;     // 0 = o_increase, 1 = o_decrease, 2 = o_theta_reset
    int unsigned start;  // cycle of the falling edge
    int unsigned width;
  } pulse_t;

  pulse_t exp_q[$];

  task automatic expect_pulse(input int unsigned ch, input int unsigned start,
                              input int unsigned width);
    pulse_t p;
    p.ch = ch; p.start = start; p.width = width;
    exp_q.push_back(p);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: sampled on the falling clock edge, away from the active edge.
  logic [2:0]  prev = '1;
  logic [2:0]  cur;
  int unsigned t_fall [3];
  pulse_t      got;

  always @(negedge clk) begin
    cur = {o_theta_reset, o_decrease, o_increase};
    tests++;
    if (!cur[0] && !cur[1]) begin
      fails++;
      $display("FAIL exclusivity at cycle %0d: inc=%b dec=%b, expected not both low",
               cyc, cur[0], cur[1]);
    end
    for (int c = 0; c < 3; c++) begin
      if (prev[c] && !cur[c]) begin
        t_fall[c] = cyc;
      end else if (!prev[c] && cur[c]) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL pulse: got ch%0d start %0d width %0d, expected no pulse",
                   c, t_fall[c], cyc - t_fall[c]);
        end else begin
          got = exp_q.pop_front();
          if (got.ch != c || got.start != t_fall[c] || got.width != cyc - t_fall[c]) begin
            fails++;
            $display("FAIL pulse: got ch%0d start %0d width %0d, expected ch%0d start %0d width %0d",
                     c, t_fall[c], cyc - t_fall[c], got.ch, got.start, got.width);
          end
        end
      end
    end
    prev = cur;
  end

  initial begin
    #100000;
    fails++;
    $display("FAIL watchdog: got timeout, expected stimulus to complete");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    int unsigned c;

    // 1. Reset with keys released
    tick(3);
    check("rst_inc", 32'(o_increase), 32'd1);
    check("rst_dec", 32'(o_decrease), 32'd1);
    check("rst_trst", 32'(o_theta_reset), 32'd1);
    check("rst_state", 32'(o_state), 32'd0);
    rst = 1'b0;
    tick(2);

    // 1b. Reset while o_increase is low, key held through deassertion
    c = cyc;
    k_inc = 1'b0;
    tick(7);
    check("pre_rst_inc_low", 32'(o_increase), 32'd0);
    rst = 1'b1;
    #1;
    check("async_rst_inc", 32'(o_increase), 32'd1);
    check("async_rst_state", 32'(o_state), 32'd0);
    tick(3);
    rst = 1'b0;
    c = cyc;
    expect_pulse(0, c + 7, PW);
    tick(10);
    k_inc = 1'b1;
    tick(20);
    check("rst_rearm_drained", 32'(exp_q.size()), 32'd0);

    // 2. Single clean press
    c = cyc;
    k_inc = 1'b0;
    expect_pulse(0, c + 7, PW);
    tick(15);
    k_inc = 1'b1;
    tick(15);
    check("single_state", 32'(o_state), 32'd0);
    check("single_drained", 32'(exp_q.size()), 32'd0);

    // 3. Bounce rejection
    repeat (4) begin
      k_inc = 1'b0; tick(2);
      k_inc = 1'b1; tick(2);
    end
    check("bounce22_state", 32'(o_state), 32'd0);
    repeat (4) begin
      k_inc = 1'b0; tick(3);
      k_inc = 1'b1; tick(1);
    end
    tick(10);
    check("bounce31_state", 32'(o_state), 32'd0);

    // 4. Auto-repeat on dec
    c = cyc;
    k_dec = 1'b0;
    expect_pulse(1, c + 7,  PW);
    expect_pulse(1, c + 31, PW);
    expect_pulse(1, c + 45, PW);
    expect_pulse(1, c + 59, PW);
    expect_pulse(1, c + 73, PW);
    tick(40);
    check("repeat_hold_state", 32'(o_state), 32'd2);
    tick(40);
    k_dec = 1'b1;
    tick(20);
    check("repeat_drained", 32'(exp_q.size()), 32'd0);
    check("repeat_state", 32'(o_state), 32'd0);

    // 5a. Simultaneous inc and dec
    k_inc = 1'b0;
    k_dec = 1'b0;
    tick(12);
    check("conflict_lockout", 32'(o_state), 32'd3);
    tick(8);
    k_inc = 1'b1;
    k_dec = 1'b1;
    tick(10);
    check("conflict_idle", 32'(o_state), 32'd0);

    // 5b. Dec alone afterwards
    c = cyc;
    k_dec = 1'b0;
    expect_pulse(1, c + 7, PW);
    tick(10);
    k_dec = 1'b1;
    tick(15);
    check("dec_alone_drained", 32'(exp_q.size()), 32'd0);

    // 5c. Dec pressed during inc HOLD
    c = cyc;
    k_inc = 1'b0;
    expect_pulse(0, c + 7, PW);
    tick(10);
    k_dec = 1'b0;
    tick(10);
    check("hold_conflict_lockout", 32'(o_state), 32'd3);
    tick(5);
    k_inc = 1'b1;
    k_dec = 1'b1;
    tick(15);
    check("hold_conflict_idle", 32'(o_state), 32'd0);
    check("hold_conflict_drained", 32'(exp_q.size()), 32'd0);

    // 6. Theta reset aborts an in-flight repeat pulse
    c = cyc;
    k_inc = 1'b0;
    expect_pulse(0, c + 7,  PW);
    expect_pulse(0, c + 31, 1);
    expect_pulse(2, c + 32, 30);
    expect_pulse(0, c + 62, PW);
    tick(25);
    k_rst = 1'b0;
    tick(10);
    check("trst_low", 32'(o_theta_reset), 32'd0);
    check("trst_forced_idle", 32'(o_state), 32'd0);
    check("trst_inc_high", 32'(o_increase), 32'd1);
    tick(20);
    k_rst = 1'b1;
    tick(9);
    k_inc = 1'b1;
    tick(20);
    check("trst_drained", 32'(exp_q.size()), 32'd0);
    check("trst_released", 32'(o_theta_reset), 32'd1);
    check("trst_final_state", 32'(o_state), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
